// File: rtl/fix_parser_pkg.sv
// Shared types for the FIX message framer: framer states and the
// per-message descriptor {start, end_addr, len} handed to the parser.
package fix_parser_pkg;

  localparam int CAM_AW = 5;

  typedef enum logic [1:0] {
    IDLE,
    IN_MSG,
    DROP
  } frame_state_e;

  typedef struct packed {
    logic [CAM_AW-1:0] start;
    logic [CAM_AW-1:0] end_addr;
    logic [CAM_AW:0]   len;
  } msg_desc_t;

  // Circular length; a zero difference means the whole CAM.
  function automatic logic [CAM_AW:0] msg_len(
    input logic [CAM_AW-1:0] s,
    input logic [CAM_AW-1:0] e
  );
    logic [CAM_AW-1:0] d;
    d = e - s + CAM_AW'(1);
    return (d == '0) ? {1'b1, {CAM_AW{1'b0}}} : {1'b0, d};
  endfunction

endpackage

// File: rtl/fix_msg_frame_ctrl_if.sv
// Beat-in / CAM-write-out bus of the FIX framer.
// slave: framer side; master: aligner/CAM side.
interface fix_msg_frame_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  wr_cs_i;
  logic                  wr_en_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  start_message_i;
  logic                  end_message_i;
  logic                  cam_write_o;
  logic [ADDR_WIDTH-1:0] cam_write_index_o;
  logic [DATA_WIDTH-1:0] cam_write_data_o;

  modport slave (
    input  wr_cs_i, wr_en_i, data_i,
    input  start_message_i, end_message_i,
    output cam_write_o, cam_write_index_o,
    output cam_write_data_o
  );

  modport master (
    output wr_cs_i, wr_en_i, data_i,
    output start_message_i, end_message_i,
    input  cam_write_o, cam_write_index_o,
    input  cam_write_data_o
  );
endinterface

// File: rtl/fix_desc_fifo.sv
// Sync FWFT FIFO of message descriptors.
// Ports: clk, rst, push_i/din_i, pop_i, head_o, full_o, empty_o.
module fix_desc_fifo
  import fix_parser_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  msg_desc_t din_i,
  input  logic      pop_i,
  output msg_desc_t head_o,
  output logic      full_o,
  output logic      empty_o
);
  localparam int PW = $clog2(DEPTH);

  msg_desc_t   mem_q [DEPTH];
  logic [PW:0] wp_q;
  logic [PW:0] rp_q;
  logic        do_push;
  logic        do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[PW] != rp_q[PW]) &&
                   (wp_q[PW-1:0] == rp_q[PW-1:0]);
  assign head_o  = mem_q[rp_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + (PW+1)'(1);
      if (do_pop)  rp_q <= rp_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[PW-1:0]] <= din_i;
  end
endmodule

// File: rtl/fix_msg_frame_ctrl.sv
// Frames FIX beats into messages in a circular CAM, queues descriptors.
// Ports: clk, rst, bus (beats in / CAM write out), desc_*, flags.
module fix_msg_frame_ctrl
  import fix_parser_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = CAM_AW,
  parameter int DESC_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  fix_msg_frame_ctrl_if.slave   bus,
  output logic                  desc_valid_o,
  output logic [ADDR_WIDTH-1:0] desc_start_addr_o,
  output logic [ADDR_WIDTH-1:0] desc_end_addr_o,
  output logic [ADDR_WIDTH:0]   desc_len_o,
  input  logic                  desc_pop_i,
  output logic                  cam_full_o,
  output logic                  msg_drop_o,
  output logic                  stray_beat_o
);
  localparam logic [ADDR_WIDTH:0] OCC_FULL =
    (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  frame_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] mstart_q, mstart_d;
  logic [ADDR_WIDTH:0]   plen_q, plen_d;
  logic [ADDR_WIDTH:0]   occ_q, occ_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  drop_q, drop_d;
  logic                  stray_q, stray_d;

  logic                  beat, sm, em;
  logic                  begin_msg;
  logic [ADDR_WIDTH-1:0] base_ptr;
  logic [ADDR_WIDTH:0]   base_occ;
  logic [ADDR_WIDTH:0]   rel_len;
  logic [ADDR_WIDTH:0]   pop_len;
  logic                  push, pop;
  msg_desc_t             push_desc, head;
  logic                  q_full, q_empty;

  assign beat = bus.wr_cs_i & bus.wr_en_i;
  assign sm   = bus.start_message_i;
  assign em   = bus.end_message_i;
  assign pop  = ~q_empty & desc_pop_i;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    mstart_d  = mstart_q;
    plen_d    = plen_q;
    we_d      = 1'b0;
    idx_d     = idx_q;
    dat_d     = dat_q;
    drop_d    = 1'b0;
    stray_d   = 1'b0;
    begin_msg = 1'b0;
    base_ptr  = wr_ptr_q;
    base_occ  = occ_q;
    rel_len   = '0;
    push      = 1'b0;
    push_desc = '0;
    if (beat) begin
      unique case (state_q)
        IDLE: begin
          if (sm) begin_msg = 1'b1;
          else    stray_d   = 1'b1;
        end
        IN_MSG: begin
          if (sm) begin
            // Abort open message, restart from its slot.
            drop_d    = 1'b1;
            rel_len   = plen_q;
            base_ptr  = mstart_q;
            base_occ  = occ_q - plen_q;
            begin_msg = 1'b1;
          end else if (occ_q == OCC_FULL || (em && q_full)) begin
            drop_d   = 1'b1;
            rel_len  = plen_q;
            wr_ptr_d = mstart_q;
            plen_d   = '0;
            state_d  = em ? IDLE : DROP;
          end else begin
            we_d     = 1'b1;
            idx_d    = wr_ptr_q;
            dat_d    = bus.data_i;
            wr_ptr_d = wr_ptr_q + ONE;
            plen_d   = plen_q + (ADDR_WIDTH+1)'(1);
            if (em) begin
              push      = 1'b1;
              push_desc = '{mstart_q, wr_ptr_q,
                            msg_len(mstart_q, wr_ptr_q)};
              plen_d    = '0;
              state_d   = IDLE;
            end
          end
        end
        DROP: begin
          if (sm)      begin_msg = 1'b1;
          else if (em) state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
      if (begin_msg) begin
        if (base_occ == OCC_FULL || (em && q_full)) begin
          drop_d   = 1'b1;
          wr_ptr_d = base_ptr;
          plen_d   = '0;
          state_d  = em ? IDLE : DROP;
        end else begin
          mstart_d = base_ptr;
          we_d     = 1'b1;
          idx_d    = base_ptr;
          dat_d    = bus.data_i;
          wr_ptr_d = base_ptr + ONE;
          if (em) begin
            push      = 1'b1;
            push_desc = '{base_ptr, base_ptr,
                          (ADDR_WIDTH+1)'(1)};
            plen_d    = '0;
            state_d   = IDLE;
          end else begin
            plen_d  = (ADDR_WIDTH+1)'(1);
            state_d = IN_MSG;
          end
        end
      end
    end
    pop_len = pop ? head.len : '0;
    if (pop) rd_ptr_d = head.end_addr + ONE;
    occ_d = occ_q - rel_len - pop_len
          + (ADDR_WIDTH+1)'(we_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mstart_q <= '0;
      plen_q   <= '0;
      occ_q    <= '0;
      we_q     <= 1'b0;
      idx_q    <= '0;
      dat_q    <= '0;
      drop_q   <= 1'b0;
      stray_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mstart_q <= mstart_d;
      plen_q   <= plen_d;
      occ_q    <= occ_d;
      we_q     <= we_d;
      idx_q    <= idx_d;
      dat_q    <= dat_d;
      drop_q   <= drop_d;
      stray_q  <= stray_d;
    end
  end

  fix_desc_fifo #(
    .DEPTH (DESC_DEPTH)
  ) u_desc_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (push_desc),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  assign bus.cam_write_o       = we_q;
  assign bus.cam_write_index_o = idx_q;
  assign bus.cam_write_data_o  = dat_q;
  assign desc_valid_o      = ~q_empty;
  assign desc_start_addr_o = q_empty ? '0 : head.start;
  assign desc_end_addr_o   = q_empty ? '0 : head.end_addr;
  assign desc_len_o        = q_empty ? '0 : head.len;
  assign cam_full_o        = (occ_q == OCC_FULL);
  assign msg_drop_o        = drop_q;
  assign stray_beat_o      = stray_q;

  // Oldest live message always begins at the release pointer.
  a_head_at_rd: assert property (@(posedge clk) disable iff (rst)
    desc_valid_o |-> (head.start == rd_ptr_q));
endmodule
